// File: rtl/dff_shift_reg_p.sv
// dff_shift_reg_p: WIDTH-bit register bank with synchronous Reset/Set and a clock enable.
// Four modes: hold, shift right, shift left, parallel load. It drives true and complement
// outputs and serial taps. A shift counter pulses word_done after every WIDTH shifts.

// Single bit of the bank: picks its next value from the hold, shift or load sources.
module dff_shift_reg_p_cell (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Set,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       d_i,
  input  logic       from_hi_i,   // neighbour toward MSB, used on shift right
  input  logic       from_lo_i,   // neighbour toward LSB, used on shift left
  output logic       q_o,
  output logic       nq_o
);
  logic q_q, q_d;
  logic nq_q;

  // Mode mux; only Reset/Set bypass the enable.
  always_comb begin
    q_d = q_q;
    if (en) begin
      case (mode)
        2'b01:   q_d = from_hi_i;
        2'b10:   q_d = from_lo_i;
        2'b11:   q_d = d_i;
        default: q_d = q_q;
      endcase
    end
  end

  // True and complement are both registered so n_q never glitches relative to q.
  always_ff @(posedge clk) begin
    if (Reset) begin
      q_q  <= 1'b0;
      nq_q <= 1'b1;
    end else if (Set) begin
      q_q  <= 1'b1;
      nq_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      nq_q <= ~q_d;
    end
  end

  assign q_o  = q_q;
  assign nq_o = nq_q;
endmodule

module dff_shift_reg_p #(
  parameter int WIDTH  = 8,
  parameter bit ROTATE = 1'b0,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Set,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_msb,
  input  logic             sin_lsb,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] n_q,
  output logic             so_lsb,
  output logic             so_msb,
  output logic [CW-1:0]    shift_cnt,
  output logic             word_done
);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  logic [WIDTH-1:0] from_hi, from_lo;
  logic             fill_r, fill_l;
  logic             shift;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wd_q, wd_d;

  // When rotating, the bit leaving one end re-enters at the other end.
  assign fill_r = ROTATE ? q[0]       : sin_msb;
  assign fill_l = ROTATE ? q[WIDTH-1] : sin_lsb;

  // Neighbour wiring: shift right pulls from i+1, shift left pulls from i-1.
  assign from_hi = {fill_r, q[WIDTH-1:1]};
  assign from_lo = {q[WIDTH-2:0], fill_l};

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      dff_shift_reg_p_cell u_cell (
        .clk       (clk),
        .Reset     (Reset),
        .Set       (Set),
        .en        (en),
        .mode      (mode),
        .d_i       (d[i]),
        .from_hi_i (from_hi[i]),
        .from_lo_i (from_lo[i]),
        .q_o       (q[i]),
        .nq_o      (n_q[i])
      );
    end
  endgenerate

  // Taps expose the current register contents with no added latency.
  assign so_lsb = q[0];
  assign so_msb = q[WIDTH-1];

  assign shift = en & (mode == 2'b01 || mode == 2'b10);

  // Word counter: both directions count. A load restarts the word. Hold keeps the count.
  always_comb begin
    cnt_d = cnt_q;
    wd_d  = 1'b0;
    if (shift) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
        wd_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (en && mode == 2'b11) begin
      cnt_d = '0;
    end
  end

  // Reset and Set both discard a partial word without flagging it.
  always_ff @(posedge clk) begin
    if (Reset || Set) begin
      cnt_q <= '0;
      wd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wd_q  <= wd_d;
    end
  end

  assign shift_cnt = cnt_q;
  assign word_done = wd_q;
endmodule

// File: tb/tb_dff_shift_reg_p.sv
// Directed bench for dff_shift_reg_p. It instantiates one copy with ROTATE=0 and one with
// ROTATE=1, and both copies share the same stimulus.
module tb_dff_shift_reg_p;
  logic       clk = 1'b0;
  logic       Reset, Set, en, sin_msb, sin_lsb;
  logic [1:0] mode;
  logic [7:0] d;
  logic [7:0] q0, nq0, q1, nq1;
  logic [2:0] cnt0, cnt1;
  logic       sl0, sm0, wd0, sl1, sm1, wd1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dff_shift_reg_p #(.WIDTH(8), .ROTATE(1'b0)) u_r0 (
    .clk(clk), .Reset(Reset), .Set(Set), .en(en), .mode(mode), .d(d),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q0), .n_q(nq0),
    .so_lsb(sl0), .so_msb(sm0), .shift_cnt(cnt0), .word_done(wd0));

  dff_shift_reg_p #(.WIDTH(8), .ROTATE(1'b1)) u_r1 (
    .clk(clk), .Reset(Reset), .Set(Set), .en(en), .mode(mode), .d(d),
    .sin_msb(sin_msb), .sin_lsb(sin_lsb), .q(q1), .n_q(nq1),
    .so_lsb(sl1), .so_msb(sm1), .shift_cnt(cnt1), .word_done(wd1));

  // One edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Reset = 0; Set = 0; en = 0; mode = 2'b00; d = 8'h00; sin_msb = 0; sin_lsb = 0;
  endtask

  task automatic test_reset();
    idle(); Reset = 1; step(); Reset = 0;
    checks++; if (q0 !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", q0); end
    checks++; if (nq0 !== 8'hFF) begin errors++; $display("FAIL reset_nq got=%h exp=FF", nq0); end
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt0); end
    checks++; if (wd0 !== 1'b0) begin errors++; $display("FAIL reset_wd got=%b exp=0", wd0); end
    checks++; if (q1 !== 8'h00 || nq1 !== 8'hFF) begin errors++; $display("FAIL reset_rot q=%h nq=%h exp=00/FF", q1, nq1); end
  endtask

  task automatic test_load();
    en = 1; mode = 2'b11; d = 8'hA5; step(); mode = 2'b00;
    checks++; if (q0 !== 8'hA5) begin errors++; $display("FAIL load_q got=%h exp=A5", q0); end
    checks++; if (nq0 !== 8'h5A) begin errors++; $display("FAIL load_nq got=%h exp=5A", nq0); end
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL load_cnt got=%0d exp=0", cnt0); end
    checks++; if (sl0 !== 1'b1 || sm0 !== 1'b1) begin errors++; $display("FAIL load_taps got=%b%b exp=11", sm0, sl0); end
  endtask

  task automatic test_shift_right();
    logic [7:0] exp_q [8] = '{8'hD2, 8'hE9, 8'hF4, 8'hFA, 8'hFD, 8'hFE, 8'hFF, 8'hFF};
    en = 1; mode = 2'b01; sin_msb = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (q0 !== exp_q[i]) begin errors++; $display("FAIL shr_q[%0d] got=%h exp=%h", i, q0, exp_q[i]); end
      checks++; if (nq0 !== ~exp_q[i]) begin errors++; $display("FAIL shr_nq[%0d] got=%h exp=%h", i, nq0, ~exp_q[i]); end
      checks++; if (cnt0 !== 3'((i + 1) % 8)) begin errors++; $display("FAIL shr_cnt[%0d] got=%0d exp=%0d", i, cnt0, (i + 1) % 8); end
      checks++; if (wd0 !== (i == 7)) begin errors++; $display("FAIL shr_wd[%0d] got=%b exp=%b", i, wd0, i == 7); end
    end
    mode = 2'b00; step();
    checks++; if (wd0 !== 1'b0) begin errors++; $display("FAIL shr_wd_drop got=%b exp=0", wd0); end
    checks++; if (sl0 !== 1'b1 || sm0 !== 1'b1) begin errors++; $display("FAIL shr_taps got=%b%b exp=11", sm0, sl0); end
  endtask

  // The count carries across a change of direction partway through a word.
  task automatic test_mixed_dir();
    en = 1; mode = 2'b11; d = 8'h00; step();
    mode = 2'b01; sin_msb = 1;
    repeat (4) step();
    checks++; if (q0 !== 8'hF0 || cnt0 !== 3'd4) begin errors++; $display("FAIL mix_half q=%h cnt=%0d exp=F0/4", q0, cnt0); end
    checks++; if (sl0 !== 1'b0 || sm0 !== 1'b1) begin errors++; $display("FAIL mix_taps got=%b%b exp=10", sm0, sl0); end
    mode = 2'b10; sin_lsb = 0;
    repeat (3) step();
    checks++; if (q0 !== 8'h80 || cnt0 !== 3'd7 || wd0 !== 1'b0) begin errors++; $display("FAIL mix_7 q=%h cnt=%0d wd=%b exp=80/7/0", q0, cnt0, wd0); end
    step();
    checks++; if (q0 !== 8'h00 || cnt0 !== 3'd0 || wd0 !== 1'b1) begin errors++; $display("FAIL mix_8 q=%h cnt=%0d wd=%b exp=00/0/1", q0, cnt0, wd0); end
    mode = 2'b00;
  endtask

  task automatic test_enable_hold();
    en = 1; mode = 2'b11; d = 8'h00; step();
    mode = 2'b01; sin_msb = 1;
    repeat (3) step();
    en = 0; mode = 2'b01;
    repeat (5) step();
    checks++; if (q0 !== 8'hE0) begin errors++; $display("FAIL en0_q got=%h exp=E0", q0); end
    checks++; if (nq0 !== 8'h1F) begin errors++; $display("FAIL en0_nq got=%h exp=1F", nq0); end
    checks++; if (cnt0 !== 3'd3 || wd0 !== 1'b0) begin errors++; $display("FAIL en0_cnt cnt=%0d wd=%b exp=3/0", cnt0, wd0); end
    en = 1; mode = 2'b00; step();
    checks++; if (q0 !== 8'hE0 || cnt0 !== 3'd3) begin errors++; $display("FAIL hold q=%h cnt=%0d exp=E0/3", q0, cnt0); end
  endtask

  // Runs with en=0 to show Reset/Set ignore the enable.
  task automatic test_reset_set();
    en = 0; Reset = 1; Set = 1; step();
    checks++; if (q0 !== 8'h00 || nq0 !== 8'hFF) begin errors++; $display("FAIL rs_both q=%h nq=%h exp=00/FF", q0, nq0); end
    checks++; if (cnt0 !== 3'd0) begin errors++; $display("FAIL rs_both_cnt got=%0d exp=0", cnt0); end
    en = 1; mode = 2'b01; step();
    en = 0; Reset = 0; Set = 1; step(); Set = 0;
    checks++; if (q0 !== 8'hFF || nq0 !== 8'h00) begin errors++; $display("FAIL set q=%h nq=%h exp=FF/00", q0, nq0); end
    checks++; if (cnt0 !== 3'd0 || wd0 !== 1'b0) begin errors++; $display("FAIL set_cnt cnt=%0d wd=%b exp=0/0", cnt0, wd0); end
  endtask

  task automatic test_rotate();
    logic [7:0] exp_q [8] = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
    en = 1; mode = 2'b11; d = 8'h81; step();
    mode = 2'b10; sin_lsb = 0; sin_msb = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (q1 !== exp_q[i]) begin errors++; $display("FAIL rot_q[%0d] got=%h exp=%h", i, q1, exp_q[i]); end
      checks++; if (wd1 !== (i == 7)) begin errors++; $display("FAIL rot_wd[%0d] got=%b exp=%b", i, wd1, i == 7); end
    end
    checks++; if (cnt1 !== 3'd0 || nq1 !== 8'h7E) begin errors++; $display("FAIL rot_end cnt=%0d nq=%h exp=0/7E", cnt1, nq1); end
    // Right rotate moves the LSB into the MSB.
    mode = 2'b01; step();
    checks++; if (q1 !== 8'hC0) begin errors++; $display("FAIL rot_r got=%h exp=C0", q1); end
    // Repeat, with a reset partway through the word.
    mode = 2'b11; d = 8'h81; step();
    mode = 2'b10;
    repeat (3) step();
    checks++; if (q1 !== 8'h0C || cnt1 !== 3'd3) begin errors++; $display("FAIL rot_mid q=%h cnt=%0d exp=0C/3", q1, cnt1); end
    Reset = 1; step(); Reset = 0;
    checks++; if (q1 !== 8'h00 || cnt1 !== 3'd0 || wd1 !== 1'b0) begin errors++; $display("FAIL rot_rst q=%h cnt=%0d wd=%b exp=00/0/0", q1, cnt1, wd1); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (wd1 !== 1'b0) begin errors++; $display("FAIL rot_nowd[%0d] got=%b exp=0", i, wd1); end
    end
    checks++; if (cnt1 !== 3'd5) begin errors++; $display("FAIL rot_cnt5 got=%0d exp=5", cnt1); end
    mode = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    #2;
    test_reset();
    test_load();
    test_shift_right();
    test_mixed_dir();
    test_enable_hold();
    test_reset_set();
    test_rotate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
